pixel_stream_src: RTL and testbench
===================================

Name: pixel_stream_src

Overview:
- Parametrised successor to the single-strip pixel source.
- Reads N pixel words from the frame RAM and serialises each to a bit stream for the NeoPixel bit encoder, using a valid/ready bit handshake.
- Then holds a programmable reset/latch gap.
- Adds:
  - runtime LED count
  - 24/32-bit pixels (RGB/RGBW)
  - MSB/LSB order
  - one-word prefetch so inter-pixel bit flow is gapless
  - loop mode and abort

Parameters:
- ADDR_W, 6: RAM address width; DEPTH = 2^ADDR_W pixels max.
- WORD_W, 32: RAM data width.
- PIX_BITS, 24: bits sent per pixel, taken from ram_q[PIX_BITS-1:0]; legal range 1..WORD_W.
- RD_LAT, 2: RAM read latency in clk cycles (>=1).
- GAP_CYCLES, 10200: reset/latch gap length in clk cycles (51 us at 200 MHz).
- MSB_FIRST, 1: 1 sends bit PIX_BITS-1 first; 0 sends bit 0 first.

Ports:
- clk  in  1  clock
- Rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame request; sampled only in IDLE
- loop  in  1  at end of GAP, restart automatically if high
- abort  in  1  synchronous cancel of current frame
- led_count  in  ADDR_W+1  pixels per frame, latched at start
- ram_rd_en  out  1  one-cycle read strobe
- ram_addr  out  ADDR_W  read address, valid while ram_rd_en=1
- ram_q  in  WORD_W  read data, valid RD_LAT cycles after strobe
- bit_data  out  1  current bit
- bit_valid  out  1  bit_data valid
- bit_ready  in  1  encoder accepts bit when bit_valid&bit_ready
- bit_last  out  1  qualifies final bit of the frame
- busy  out  1  high from start acceptance through end of GAP
- frame_done  out  1  one-cycle pulse at end of GAP
- cur_pix  out  ADDR_W  index of pixel being shifted (debug)

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and registers cleared; no read outstanding.
- States: IDLE, RUN, GAP.

IDLE:
- start=1 and led_count!=0 in cycle T: latch count (values >DEPTH clamp to DEPTH); busy=1 and ram_rd_en=1 with ram_addr=0 in cycle T+1; go to RUN.
- start with led_count=0: ignored; busy stays 0; no frame_done.

RUN:
- Shift register, 1-word hold register, and a read-outstanding flag; at most one read in flight.
- RAM data is captured at the end of cycle strobe+RD_LAT:
  - into the shifter if it is empty;
  - otherwise into hold.
- A new read issues when no read is outstanding, hold is empty, and the fetched count is below the latched count. Addresses increment 0,1,…,count-1 with no wrap.
- First bit_valid appears in cycle T+2+RD_LAT (RD_LAT=2 gives T+4).
- bit_valid holds and bit_data stays stable until accepted; no combinational path from bit_ready to bit_valid.
- On the transfer of a pixel's last bit:
  - hold loads into the shifter in the same edge, so bit_valid stays 1 the next cycle (no bubble when hold is full);
  - if hold is empty, bit_valid drops until data arrives.
- cur_pix increments on each pixel change.
- bit_last=1 on bit PIX_BITS-1 of pixel count-1; its transfer moves the block to GAP.

GAP:
- Counter runs 0..GAP_CYCLES-1; bit_valid=0.
- In the final cycle: frame_done=1.
- Next state:
  - loop=1 with latched-sample rules as for start (led_count re-latched, 0 → IDLE): back to RUN, issuing ram_addr=0, with busy staying 1.
  - otherwise IDLE, busy=0.

abort (any state except IDLE):
- Next cycle: IDLE, busy=0, bit_valid=0, hold/shifter/outstanding cleared; no frame_done.
- Any RAM data returning afterwards is discarded.
- abort has priority over every other event in the same cycle.

Other rules:
- start while busy: ignored.
- Rst_n assertion mid-frame: immediate return to the reset values.
- bit_ready held low indefinitely: block stalls in RUN with no timeout; the GAP counter does not run.

Test Plan:
1. led_count=3, words 0xA5F00F, 0x123456, 0xFFFFFF, bit_ready=1 constant, RD_LAT=2 → 72 bits MSB-first with no bubble after the first; bit_last on bit 72; frame_done exactly GAP_CYCLES cycles after the last transfer; ram_addr sequence 0,1,2 only.
2. MSB_FIRST=0, PIX_BITS=32, led_count=1, word 0x80000001 → bits 1,0…0,1 (32 bits); bit_last on bit 32.
3. bit_ready random ~30% high → bit sequence identical to scenario 1; bit_data never changes while bit_valid=1 and bit_ready=0.
4. loop=1, led_count=2 → frames repeat; busy never drops; ram_addr restarts at 0 the cycle after each frame_done.
5. abort mid-pixel 1 of 4 → next cycle busy=0, bit_valid=0; no frame_done; later start runs a full clean frame from addr 0.
6. start with led_count=0 → no ram_rd_en, busy stays 0; led_count=100 with ADDR_W=6 → exactly 64 pixels sent.

Source files
------------

// File: rtl/pixel_stream_src.sv
// Frame-RAM to bit-stream source for a NeoPixel encoder: fetches led_count pixel words,
// shifts them out over a valid/ready bit handshake, then holds the latch gap.
`timescale 1ns/1ps
module pixel_stream_src #(
  parameter int ADDR_W     = 6,
  parameter int WORD_W     = 32,
  parameter int PIX_BITS   = 24,
  parameter int RD_LAT     = 2,
  parameter int GAP_CYCLES = 10200,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  input  logic [ADDR_W:0]   led_count,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WORD_W-1:0] ram_q,
  output logic              bit_data,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] cur_pix
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int BIT_W = $clog2(PIX_BITS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIX_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    fetch_q;
  logic [CNT_W-1:0]    pix_q;
  logic [RD_LAT-1:0]   rd_pipe_q;
  logic [PIX_BITS-1:0] sh_q;
  logic                sh_valid_q;
  logic [PIX_BITS-1:0] hold_q;
  logic                hold_valid_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [GAP_W-1:0]    gap_q;

  logic [CNT_W-1:0]    count_lim;
  logic [PIX_BITS-1:0] pix_word;
  logic abort_now, frame_begin, xfer, pix_end, last_pix, frame_end, gap_end;
  logic rd_issue, rd_land, land_to_sh, land_to_hold;

  assign count_lim   = (led_count > DEPTH_C) ? DEPTH_C : led_count;
  assign pix_word    = ram_q[PIX_BITS-1:0];
  assign abort_now   = abort && (state_q != S_IDLE);
  assign frame_begin = (state_d == S_RUN) && (state_q != S_RUN);
  assign xfer        = sh_valid_q && bit_ready;
  assign pix_end     = xfer && (bit_cnt_q == LAST_BIT);
  assign last_pix    = (pix_q == count_q - CNT_W'(1));
  assign frame_end   = pix_end && last_pix;
  assign gap_end     = (state_q == S_GAP) && (gap_q == GAP_LAST);
  // Single read in flight, and only when there is somewhere to put the word.
  assign rd_issue    = (state_q == S_RUN) && !(|rd_pipe_q) && !hold_valid_q && (fetch_q < count_q);
  assign rd_land     = rd_pipe_q[RD_LAT-1];
  assign land_to_sh  = rd_land && (!sh_valid_q || (pix_end && !hold_valid_q));
  assign land_to_hold = rd_land && !land_to_sh;

  generate
    if (PIX_BITS < WORD_W) begin : g_hi
      logic unused_ram_hi;
      assign unused_ram_hi = ^ram_q[WORD_W-1:PIX_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (led_count != '0)) state_d = S_RUN;
      S_RUN:   if (frame_end) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = (loop && (led_count != '0)) ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_now) state_d = S_IDLE;
  end

  always_comb begin
    ram_rd_en  = rd_issue;
    ram_addr   = fetch_q[ADDR_W-1:0];
    busy       = (state_q != S_IDLE);
    bit_valid  = sh_valid_q;
    bit_data   = (MSB_FIRST != 0) ? sh_q[PIX_BITS-1] : sh_q[0];
    bit_last   = sh_valid_q && last_pix && (bit_cnt_q == LAST_BIT);
    frame_done = gap_end && !abort;
    cur_pix    = pix_q[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q      <= '0;
      fetch_q      <= '0;
      pix_q        <= '0;
      rd_pipe_q    <= '0;
      sh_q         <= '0;
      sh_valid_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
    end else if (abort_now || frame_begin) begin
      // Dropping rd_pipe_q here discards any word still in flight.
      fetch_q      <= '0;
      pix_q        <= '0;
      rd_pipe_q    <= '0;
      sh_valid_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      if (frame_begin) count_q <= count_lim;
    end else begin
      rd_pipe_q <= RD_LAT'({rd_pipe_q, rd_issue});
      if (rd_issue) fetch_q <= fetch_q + CNT_W'(1);
      gap_q <= ((state_q == S_GAP) && !gap_end) ? gap_q + GAP_W'(1) : '0;

      if (pix_end) begin
        bit_cnt_q <= '0;
        if (!last_pix) pix_q <= pix_q + CNT_W'(1);
        if (hold_valid_q) begin
          sh_q         <= hold_q;
          hold_valid_q <= 1'b0;
        end else if (!rd_land) begin
          sh_valid_q <= 1'b0;
        end
      end else if (xfer) begin
        sh_q      <= (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end

      if (land_to_sh) begin
        sh_q       <= pix_word;
        sh_valid_q <= 1'b1;
      end
      if (land_to_hold) begin
        hold_q       <= pix_word;
        hold_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_src.sv
// Directed/randomised bench for pixel_stream_src: two instances (MSB-first 24-bit and
// LSB-first 32-bit), RAM latency models, and a queue-based bit/address reference.
`timescale 1ns/1ps
module tb_pixel_stream_src;
  localparam int AW = 6, WW = 32, PB = 24, RL = 2, GAP = 16;
  localparam int PB_B = 32, RL_B = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start_b = 1'b0, loop = 1'b0, abort = 1'b0, bit_ready = 1'b1;
  logic [AW:0] led_count = '0;

  logic rd_en_a, bd_a, bv_a, bl_a, busy_a, fd_a;
  logic [AW-1:0] addr_a, cur_a;
  logic [WW-1:0] q_a;
  logic rd_en_b, bd_b, bv_b, bl_b, busy_b, fd_b;
  logic [AW-1:0] addr_b, cur_b;
  logic [WW-1:0] q_b;

  logic [WW-1:0] mem_a [64];
  logic [WW-1:0] mem_b [64];
  logic [WW-1:0] dl_a [RL];
  logic [WW-1:0] dl_b [RL_B];

  int n_cmp = 0, n_err = 0, cyc = 0, ready_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_stream_src #(.ADDR_W(AW), .WORD_W(WW), .PIX_BITS(PB), .RD_LAT(RL),
                     .GAP_CYCLES(GAP), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .Rst_n(rst_n), .start(start), .loop(loop), .abort(abort),
    .led_count(led_count), .ram_rd_en(rd_en_a), .ram_addr(addr_a), .ram_q(q_a),
    .bit_data(bd_a), .bit_valid(bv_a), .bit_ready(bit_ready), .bit_last(bl_a),
    .busy(busy_a), .frame_done(fd_a), .cur_pix(cur_a));

  pixel_stream_src #(.ADDR_W(AW), .WORD_W(WW), .PIX_BITS(PB_B), .RD_LAT(RL_B),
                     .GAP_CYCLES(GAP), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .Rst_n(rst_n), .start(start_b), .loop(loop), .abort(abort),
    .led_count(led_count), .ram_rd_en(rd_en_b), .ram_addr(addr_b), .ram_q(q_b),
    .bit_data(bd_b), .bit_valid(bv_b), .bit_ready(bit_ready), .bit_last(bl_b),
    .busy(busy_b), .frame_done(fd_b), .cur_pix(cur_b));

  // RAM models: data for the address presented in cycle S is on ram_q in cycle S+latency.
  always @(posedge clk) begin
    dl_a[0] <= mem_a[addr_a];
    for (int i = 1; i < RL; i++) dl_a[i] <= dl_a[i-1];
    dl_b[0] <= mem_b[addr_b];
    for (int i = 1; i < RL_B; i++) dl_b[i] <= dl_b[i-1];
  end
  assign q_a = dl_a[RL-1];
  assign q_b = dl_b[RL_B-1];

  initial forever begin
    @(posedge clk); #1;
    bit_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed traffic and the reference it is compared against.
  logic [1:0] bit_q_a[$], exp_a[$], bit_q_b[$], exp_b[$];
  int addr_q_a[$], exp_addr_a[$], rd_cyc_a[$], fd_cyc_a[$];
  int first_valid_a, last_xfer_a, busy_low_a, busy_hi_a, t_start, fd_target;
  int first_valid_b, n_fd_b;
  logic stall_pend = 1'b0, stall_bit = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en_a) begin addr_q_a.push_back(int'(addr_a)); rd_cyc_a.push_back(cyc); end
      if (bv_a && first_valid_a < 0) first_valid_a = cyc;
      if (bv_a && bit_ready) begin bit_q_a.push_back({bl_a, bd_a}); last_xfer_a = cyc; end
      if (fd_a) fd_cyc_a.push_back(cyc);
      if (busy_a) busy_hi_a++;
      else if (cyc > t_start && fd_cyc_a.size() < fd_target) busy_low_a++;
      if (stall_pend) begin
        check("stall_valid_held", bv_a, 1'b1);
        check("stall_data_stable", bd_a, stall_bit);
      end
      stall_pend = bv_a && !bit_ready;
      stall_bit  = bd_a;
      if (bv_b && first_valid_b < 0) first_valid_b = cyc;
      if (bv_b && bit_ready) bit_q_b.push_back({bl_b, bd_b});
      if (fd_b) n_fd_b++;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic clr_a();
    bit_q_a.delete(); exp_a.delete(); addr_q_a.delete(); exp_addr_a.delete();
    rd_cyc_a.delete(); fd_cyc_a.delete();
    first_valid_a = -1; last_xfer_a = -1; busy_low_a = 0; busy_hi_a = 0;
    t_start = 1 << 30; fd_target = 0;
  endtask

  // Reference frame: pixels 0..n-1, MSB first, bit_last only on the frame's final bit.
  task automatic exp_frame_a(input int n);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < PB; k++)
        exp_a.push_back({(p == n-1 && k == PB-1), mem_a[p][PB-1-k]});
      exp_addr_a.push_back(p);
    end
  endtask

  task automatic pulse(input int n, input bit sel_b);
    @(posedge clk); #1;
    led_count = (AW+1)'(n);
    if (sel_b) start_b = 1'b1; else start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_fd_a(input int n, input int budget);
    int k = 0;
    while (fd_cyc_a.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    check("frame_done_arrival", fd_cyc_a.size(), n);
  endtask

  task automatic check_frame_a(input string tag);
    int bad = 0;
    check({tag, "_nbits"}, bit_q_a.size(), exp_a.size());
    for (int i = 0; i < bit_q_a.size() && i < exp_a.size(); i++)
      if (bad == 0 && bit_q_a[i] !== exp_a[i]) bad = i + 1;
    check({tag, "_bit_last_seq_first_bad"}, bad, 0);
    bad = 0;
    check({tag, "_naddr"}, addr_q_a.size(), exp_addr_a.size());
    for (int i = 0; i < addr_q_a.size() && i < exp_addr_a.size(); i++)
      if (bad == 0 && addr_q_a[i] != exp_addr_a[i]) bad = i + 1;
    check({tag, "_addr_seq_first_bad"}, bad, 0);
  endtask

  function automatic int first_fd();
    return (fd_cyc_a.size() > 0) ? fd_cyc_a[0] : -1;
  endfunction

  initial begin
    int k, found, n_before, a_before, bad;
    for (int i = 0; i < 64; i++) begin mem_a[i] = $urandom(); mem_b[i] = $urandom(); end
    clr_a();
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_valid", bv_a, 1'b0);
    check("rst_rd_en", rd_en_a, 1'b0);
    check("rst_done", fd_a, 1'b0);
    check("rst_last", bl_a, 1'b0);
    check("rst_cur_pix", cur_a, '0);
    check("rst_b_outputs", {busy_b, bv_b, rd_en_b, fd_b, bl_b, bd_b, cur_b}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Three pixels, ready always high: gapless 72 bits, fixed latencies.
    mem_a[0] = 32'h5AA5F00F; mem_a[1] = 32'hC3123456; mem_a[2] = 32'h00FFFFFF;
    clr_a(); exp_frame_a(3); fd_target = 1;
    pulse(3, 1'b0);
    wait_fd_a(1, 400);
    check_frame_a("s1");
    check("s1_first_read_cycle", (rd_cyc_a.size() > 0) ? rd_cyc_a[0] : -1, t_start + 1);
    check("s1_first_valid_cycle", first_valid_a, t_start + 2 + RL);
    check("s1_no_bubble_span", last_xfer_a - first_valid_a + 1, 3 * PB);
    check("s1_gap_length", first_fd() - last_xfer_a, GAP);
    check("s1_busy_low_cycles", busy_low_a, 0);
    repeat (2) @(posedge clk); #1;
    check("s1_idle_after_gap", busy_a, 1'b0);

    // LSB-first 32-bit instance, single pixel.
    mem_b[0] = 32'h80000001;
    bit_q_b.delete(); exp_b.delete(); first_valid_b = -1; n_fd_b = 0;
    for (int i = 0; i < PB_B; i++) exp_b.push_back({(i == PB_B-1), mem_b[0][i]});
    pulse(1, 1'b1);
    k = 0;
    while (n_fd_b == 0 && k < 200) begin @(posedge clk); #1; k++; end
    check("s2_frame_done", n_fd_b, 1);
    check("s2_nbits", bit_q_b.size(), PB_B);
    bad = 0;
    for (int i = 0; i < bit_q_b.size() && i < exp_b.size(); i++)
      if (bad == 0 && bit_q_b[i] !== exp_b[i]) bad = i + 1;
    check("s2_bit_last_seq_first_bad", bad, 0);
    check("s2_first_valid_cycle", first_valid_b, t_start + 2 + RL_B);

    // Same frame with ~30% random ready.
    ready_mode = 1;
    clr_a(); exp_frame_a(3); fd_target = 1;
    pulse(3, 1'b0);
    wait_fd_a(1, 3000);
    check_frame_a("s3");
    check("s3_gap_length", first_fd() - last_xfer_a, GAP);
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;

    // Loop mode: three back-to-back two-pixel frames.
    clr_a(); exp_frame_a(2); exp_frame_a(2); exp_frame_a(2); fd_target = 3;
    loop = 1'b1;
    pulse(2, 1'b0);
    wait_fd_a(2, 400);
    loop = 1'b0;
    wait_fd_a(3, 400);
    check_frame_a("s4");
    check("s4_busy_low_cycles", busy_low_a, 0);
    for (int j = 0; j < 2 && j < fd_cyc_a.size(); j++) begin
      found = 0;
      for (int i = 0; i < rd_cyc_a.size(); i++)
        if (rd_cyc_a[i] == fd_cyc_a[j] + 1 && addr_q_a[i] == 0) found = 1;
      check("s4_restart_addr0_after_done", found, 1);
    end
    repeat (2) @(posedge clk); #1;
    check("s4_idle_after_loop_off", busy_a, 1'b0);

    // Abort inside pixel 1 of 4, then a clean frame.
    clr_a();
    pulse(4, 1'b0);
    k = 0;
    while (bit_q_a.size() < 30 && k < 200) begin @(posedge clk); #1; k++; end
    check("s5_reached_pixel1", bit_q_a.size() >= 30, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("s5_abort_busy", busy_a, 1'b0);
    check("s5_abort_valid", bv_a, 1'b0);
    n_before = bit_q_a.size(); a_before = addr_q_a.size();
    repeat (40) @(posedge clk); #1;
    check("s5_no_frame_done", fd_cyc_a.size(), 0);
    check("s5_no_bits_after_abort", bit_q_a.size(), n_before);
    check("s5_no_reads_after_abort", addr_q_a.size(), a_before);
    clr_a(); exp_frame_a(4); fd_target = 1;
    pulse(4, 1'b0);
    wait_fd_a(1, 600);
    check_frame_a("s5_clean");
    check("s5_clean_first_valid", first_valid_a, t_start + 2 + RL);

    // Zero count is ignored; oversize count clamps to 64 pixels.
    clr_a();
    pulse(0, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("s6_zero_no_reads", addr_q_a.size(), 0);
    check("s6_zero_busy_cycles", busy_hi_a, 0);
    check("s6_zero_no_done", fd_cyc_a.size(), 0);
    for (int i = 0; i < 64; i++) mem_a[i] = $urandom();
    clr_a(); exp_frame_a(64); fd_target = 1;
    pulse(100, 1'b0);
    wait_fd_a(1, 3000);
    check_frame_a("s6_clamp");

    // Asynchronous reset in the middle of a frame.
    clr_a();
    pulse(3, 1'b0);
    repeat (10) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("s7_rst_busy", busy_a, 1'b0);
    check("s7_rst_valid", bv_a, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("s7_idle_after_reset", {busy_a, bv_a, rd_en_a}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
